// File: rtl/bus_slave_param.sv
// Serial-framed memory slave: 3'b111 start, ID, R/W, burst, address, then bit-serial data MSB first.
// Optional BURST_WRAP_EN: bursts wrap from the top word to 0; otherwise a burst ends at the top word.
module bus_slave_param #(
    parameter int ADDR_DEPTH = 2048,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 2,
    parameter int SLAVEID    = 1,
    parameter int DELAY      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic control,
    input  logic wD,
    input  logic valid,
    input  logic last,
    output logic rD,
    output logic rValid,
    output logic ready
);
    localparam int AW   = $clog2(ADDR_DEPTH);
    localparam int HW   = 2 + ID_WIDTH + AW;
    localparam int CMAX = (HW > DATA_WIDTH) ? HW : DATA_WIDTH;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0]       HDR_LAST = CW'(HW - 1);
    localparam logic [CW-1:0]       DAT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [AW-1:0]       ADDR_MAX = AW'(ADDR_DEPTH - 1);
    localparam logic [7:0]          DLY_LAST = 8'(DELAY - 1);
    localparam logic [ID_WIDTH-1:0] MY_ID    = ID_WIDTH'(SLAVEID);

    typedef enum logic [2:0] {
        IDLE, HEADER, SKIP, WR_RX, WR_COMMIT, RD_WAIT, RD_TX
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            start_cnt_q, start_cnt_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [HW-2:0]         hdr_q, hdr_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [7:0]            delay_cnt_q, delay_cnt_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  burst_q, burst_d;
    logic                  last_seen_q, last_seen_d;
    logic [DATA_WIDTH-1:0] mem_q [ADDR_DEPTH];

    logic [HW-1:0]         hdr_full;
    logic [AW-1:0]         addr_inc;
    logic                  top_stop;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] rd_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            start_cnt_q <= '0;
            cnt_q       <= '0;
            hdr_q       <= '0;
            shift_q     <= '0;
            delay_cnt_q <= '0;
            addr_q      <= '0;
            burst_q     <= 1'b0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            shift_q     <= shift_d;
            delay_cnt_q <= delay_cnt_d;
            addr_q      <= addr_d;
            burst_q     <= burst_d;
            last_seen_q <= last_seen_d;
        end
    end

    // Gated with rst so a reset landing on the commit cycle still drops the word.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[addr_q] <= shift_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        cnt_d       = cnt_q;
        hdr_d       = hdr_q;
        shift_d     = shift_q;
        delay_cnt_d = delay_cnt_q;
        addr_d      = addr_q;
        burst_d     = burst_q;
        last_seen_d = last_seen_q;
        mem_we      = 1'b0;
        hdr_full    = {hdr_q, control};
`ifdef BURST_WRAP_EN
        top_stop = 1'b0;
        addr_inc = (addr_q == ADDR_MAX) ? '0 : addr_q + AW'(1);
`else
        top_stop = (addr_q == ADDR_MAX);
        addr_inc = addr_q + AW'(1);
`endif

        case (state_q)
            IDLE: begin
                if (!control) begin
                    start_cnt_d = '0;
                end else if (start_cnt_q == 2'd2) begin
                    start_cnt_d = '0;
                    cnt_d       = '0;
                    state_d     = HEADER;
                end else begin
                    start_cnt_d = start_cnt_q + 2'd1;
                end
            end
            HEADER: begin
                hdr_d = hdr_full[HW-2:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == HDR_LAST) begin
                    cnt_d       = '0;
                    addr_d      = hdr_full[AW-1:0];
                    burst_d     = hdr_full[AW];
                    last_seen_d = 1'b0;
                    shift_d     = '0;
                    delay_cnt_d = '0;
                    if (hdr_full[HW-1 -: ID_WIDTH] != MY_ID) begin
                        state_d = SKIP;
                    end else if (hdr_full[AW+1]) begin
                        state_d = WR_RX;
                    end else begin
                        state_d = (DELAY == 0) ? RD_TX : RD_WAIT;
                    end
                end
            end
            SKIP: begin
                if (last) begin
                    state_d = IDLE;
                end
            end
            WR_RX: begin
                if (valid) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], wD};
                    if (last) begin
                        last_seen_d = 1'b1;
                    end
                    if (cnt_q == DAT_LAST) begin
                        cnt_d   = '0;
                        state_d = WR_COMMIT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (last) begin
                    // Master abandoned the word: drop whatever was collected.
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = IDLE;
                end
            end
            WR_COMMIT: begin
                mem_we      = 1'b1;
                shift_d     = '0;
                last_seen_d = 1'b0;
                if (!burst_q || last_seen_q || top_stop) begin
                    state_d = IDLE;
                end else begin
                    addr_d  = addr_inc;
                    state_d = WR_RX;
                end
            end
            RD_WAIT: begin
                if (delay_cnt_q == DLY_LAST) begin
                    delay_cnt_d = '0;
                    state_d     = RD_TX;
                end else begin
                    delay_cnt_d = delay_cnt_q + 8'd1;
                end
            end
            RD_TX: begin
                if (last) begin
                    last_seen_d = 1'b1;
                end
                if (cnt_q == DAT_LAST) begin
                    cnt_d       = '0;
                    last_seen_d = 1'b0;
                    if (!burst_q || last_seen_q || last || top_stop) begin
                        state_d = IDLE;
                    end else begin
                        addr_d = addr_inc;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready   = 1'b1;
        rValid  = 1'b0;
        rD      = 1'b0;
        rd_bits = mem_q[addr_q] << cnt_q;
        case (state_q)
            WR_COMMIT, RD_WAIT: ready = 1'b0;
            RD_TX: begin
                rValid = 1'b1;
                rD     = rd_bits[DATA_WIDTH-1];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_bus_slave_param.sv
module tb_bus_slave_param;
    logic clk = 1'b0;
    logic rst, control, wD, valid, last;
    logic rD, rValid, ready;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q [4];

    bus_slave_param #(
        .ADDR_DEPTH(2048), .DATA_WIDTH(8), .ID_WIDTH(2), .SLAVEID(1), .DELAY(5)
    ) dut (
        .clk(clk), .rst(rst), .control(control), .wD(wD), .valid(valid), .last(last),
        .rD(rD), .rValid(rValid), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [1:0] id, input logic rw, input logic b,
                              input logic [10:0] a);
        logic [17:0] bits;
        bits = {3'b111, id, rw, b, a};
        for (int i = 17; i >= 0; i--) begin
            control = bits[i];
            tick();
        end
        control = 1'b0;
    endtask

    task automatic wr_word(input logic [7:0] d, input logic lst, input int gap_at,
                           input int gap_len);
        for (int i = 7; i >= 0; i--) begin
            if (i == gap_at) begin
                valid = 1'b0;
                repeat (gap_len) tick();
            end
            valid = 1'b1;
            wD    = d[i];
            last  = lst && (i == 0);
            tick();
        end
        valid = 1'b0;
        last  = 1'b0;
        wD    = 1'b0;
        chk("wr_commit_ready_low", ready, 0);
        tick();
        chk("wr_after_commit_ready", ready, 1);
    endtask

    task automatic rd_xfer(input logic [10:0] a, input logic b, input int nw, input logic lst);
        int cnt;
        int vc;
        logic [7:0] got;
        send_frame(2'b01, 1'b0, b, a);
        cnt = 0;
        while (ready == 1'b0 && cnt < 300) begin
            cnt++;
            tick();
        end
        chk("rd_delay_cycles", cnt, 5);
        for (int w = 0; w < nw; w++) begin
            got = '0;
            vc  = 0;
            for (int i = 0; i < 8; i++) begin
                got  = {got[6:0], rD};
                vc  += int'(rValid);
                last = lst && (w == nw - 1) && (i == 7);
                tick();
            end
            last = 1'b0;
            chk("rd_word", got, exp_q[w]);
            chk("rd_rvalid_cycles", vc, 8);
        end
        chk("rd_end_rvalid_low", rValid, 0);
    endtask

    initial begin
        rst = 1'b1; control = 1'b0; wD = 1'b0; valid = 1'b0; last = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_ready", ready, 1);
        chk("reset_rvalid", rValid, 0);
        chk("reset_rd", rD, 0);

        // Single write then single read of address 5
        send_frame(2'b01, 1'b1, 1'b0, 11'd5);
        wr_word(8'hA5, 1'b0, -1, 0);
        exp_q[0] = 8'hA5;
        rd_xfer(11'd5, 1'b0, 1, 1'b0);

        // Burst write 0..3 with an 8-cycle valid gap inside word 2
        send_frame(2'b01, 1'b1, 1'b1, 11'd0);
        wr_word(8'h11, 1'b0, -1, 0);
        wr_word(8'h22, 1'b0, 3, 8);
        wr_word(8'h33, 1'b0, -1, 0);
        wr_word(8'h44, 1'b1, -1, 0);
        exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;
        rd_xfer(11'd0, 1'b1, 4, 1'b1);

        // Foreign ID: data traffic must be ignored until last
        begin
            int rv;
            rv = 0;
            send_frame(2'b10, 1'b1, 1'b0, 11'd5);
            for (int i = 0; i < 10; i++) begin
                valid = 1'b1;
                wD    = 1'b1;
                rv   += int'(rValid);
                tick();
            end
            valid = 1'b0;
            last  = 1'b1;
            tick();
            last = 1'b0;
            chk("skip_rvalid_cycles", rv, 0);
            chk("skip_exit_ready", ready, 1);
        end
        exp_q[0] = 8'hA5;
        rd_xfer(11'd5, 1'b0, 1, 1'b0);

        // Partial word aborted by last with valid low
        send_frame(2'b01, 1'b1, 1'b0, 11'd1);
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            wD    = 1'b1;
            tick();
        end
        valid = 1'b0;
        last  = 1'b1;
        tick();
        last = 1'b0;
        chk("abort_ready", ready, 1);
        // Interrupted start pattern 1,1,0 must restart the start-bit count
        control = 1'b1; tick();
        control = 1'b1; tick();
        control = 1'b0; tick();
        exp_q[0] = 8'h22;
        rd_xfer(11'd1, 1'b0, 1, 1'b0);

        // Top-of-memory burst read
        send_frame(2'b01, 1'b1, 1'b0, 11'd2047);
        wr_word(8'h5C, 1'b0, -1, 0);
        exp_q[0] = 8'h5C;
        exp_q[1] = 8'h11;
`ifdef BURST_WRAP_EN
        rd_xfer(11'd2047, 1'b1, 2, 1'b1);
`else
        rd_xfer(11'd2047, 1'b1, 1, 1'b0);
`endif

        // Reset in the middle of a write word
        send_frame(2'b01, 1'b1, 1'b0, 11'd5);
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            wD    = 1'b0;
            tick();
        end
        valid = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ready", ready, 1);
        chk("midrst_rvalid", rValid, 0);
        chk("midrst_rd", rD, 0);
        exp_q[0] = 8'hA5;
        rd_xfer(11'd5, 1'b0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_slave_param.md
BUS_SLAVE_PARAM -- requirements
Module: bus_slave_param

Interface
REQ-001 Parameter ADDR_DEPTH, default 2048, number of DATA_WIDTH-bit memory words; ADDR_WIDTH = clog2(ADDR_DEPTH).
REQ-002 Parameter DATA_WIDTH, default 8, bits per word.
REQ-003 Parameter ID_WIDTH, default 2, bits of slave ID in the control frame.
REQ-004 Parameter SLAVEID, default 1, this slave's ID.
REQ-005 Parameter DELAY, default 5, read latency in clk cycles, range 0-255.
REQ-006 clk  in  1  single clock; all logic on posedge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 control  in  1  serial control frame, MSB first.
REQ-009 wD  in  1  serial write data, MSB first, qualified by valid.
REQ-010 valid  in  1  master write-data qualifier.
REQ-011 last  in  1  master end-of-burst / end-of-transfer flag.
REQ-012 rD  out  1  serial read data, MSB first.
REQ-013 rValid  out  1  high on every cycle rD carries a read bit.
REQ-014 ready  out  1  slave can accept header/data; default high.

Function
REQ-015 Frame: 3'b111 start, ID_WIDTH ID bits, R/W bit (1=write), B bit (1=burst), ADDR_WIDTH start address; all bits sampled one per cycle.
REQ-016 States: IDLE, HEADER, SKIP, WR_RX, WR_COMMIT, RD_WAIT, RD_TX.
REQ-017 IDLE->HEADER after three consecutive control=1 samples; a 0 restarts the start-bit count.
REQ-018 HEADER collects the remaining fields over 2+ID_WIDTH+ADDR_WIDTH cycles; ID==SLAVEID -> WR_RX (R/W=1) or RD_WAIT (R/W=0); mismatch -> SKIP.
REQ-019 SKIP ignores all inputs until last=1 is sampled, then -> IDLE.
REQ-020 control is ignored in every state except IDLE and HEADER.
REQ-021 WR_RX shifts wD in only on cycles with valid=1; valid=0 holds the shift register and bit count.
REQ-022 After DATA_WIDTH valid bits -> WR_COMMIT; the word is written to mem[addr] on that cycle, ready=0, one cycle.
REQ-023 WR_COMMIT: single transfer, or burst with last=1 sampled during the word -> IDLE; else addr+1 -> WR_RX.
REQ-024 last=1 sampled in WR_RX with valid=0 and zero bits received -> IDLE with no write; with a partial word -> IDLE, partial discarded.
REQ-025 RD_WAIT holds ready=0 for exactly DELAY cycles, then -> RD_TX; DELAY=0 goes straight to RD_TX.
REQ-026 RD_TX drives mem[addr] on rD, MSB first, one bit/cycle, rValid=1, ready=1; words back-to-back with no gap.
REQ-027 RD_TX word end: single transfer, or burst with last=1 sampled during the word -> IDLE, rValid=0; else addr+1, next word on the next cycle.
REQ-028 Address increments modulo ADDR_DEPTH only as defined under Configuration; addr never exceeds ADDR_DEPTH-1.
REQ-029 In IDLE, HEADER and SKIP: ready=1, rD=0, rValid=0.

Reset
REQ-030 rst=1 at a clock edge forces IDLE, clears start-bit count, shift register, bit count, delay counter, and addr.
REQ-031 Reset output values: rD=0, rValid=0, ready=1.
REQ-032 Memory contents are not cleared by reset.
REQ-033 Reset mid-transfer abandons the transfer; a partial write word is never committed.

Configuration
REQ-034 Macro BURST_WRAP_EN defined: burst increment from ADDR_DEPTH-1 wraps to 0 and the burst continues.
REQ-035 BURST_WRAP_EN undefined: a burst reaching ADDR_DEPTH-1 ends after that word -> IDLE, as if last=1.

Verification
REQ-036 Write single: frame 111_01_10_00000000101, wD=0xA5 with valid -> mem[5]=0xA5; ready=0 for one cycle; then IDLE.
REQ-037 Read single, DELAY=5: frame 111_01_00_00000000101 -> ready low 5 cycles, then rD=1,0,1,0,0,1,0,1 with rValid=1 for 8 cycles.
REQ-038 Write burst from addr 0, 4 words 0x11..0x44, valid gapped 8 cycles mid-word, last on word 4 -> mem[0..3]=0x11,0x22,0x33,0x44.
REQ-039 ID mismatch: frame with ID 2'b10, then wD traffic -> no memory change, rValid=0; last=1 -> IDLE.
REQ-040 Burst read at addr 2047, 2 words: BURST_WRAP_EN -> mem[2047] then mem[0]; undefined -> only mem[2047], then IDLE.
REQ-041 rst=1 after 4 bits of a write word -> outputs at reset values next cycle; target memory word unchanged.
